// File: rtl/dcache_write_through_pkg.sv
// Shared widths, memory-port encodings and FSM states for the write-through dcache.
package dcache_write_through_pkg;
  localparam int CPU_ADDR_BITS = 32;
  localparam int CPU_DATA_BITS = 32;

  localparam logic MEM_RW_READ  = 1'b0;
  localparam logic MEM_RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    DCACHE_READY,
    DCACHE_RD_REQ,
    DCACHE_RD_WAIT,
    DCACHE_WR_REQ
  } dcache_state_e;
endpackage

// File: rtl/dcache_write_through_data.sv
// Line data storage: synchronous read, per-byte write, write-first bypass on a same-index read.
module dcache_data_array #(
  parameter int LINES  = 64,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_re,
  input  logic [$clog2(LINES)-1:0]  i_raddr,
  input  logic [DATA_W/8-1:0]       i_we,
  input  logic [$clog2(LINES)-1:0]  i_waddr,
  input  logic [DATA_W-1:0]         i_wdata,
  output logic [DATA_W-1:0]         o_rdata
);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [LINES];
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] w_merged;

  // Merged line is both what gets stored and what a colliding read sees.
  always_comb begin
    w_merged = r_mem[i_waddr];
    for (int b = 0; b < NB; b++)
      if (i_we[b]) w_merged[b*8 +: 8] = i_wdata[b*8 +: 8];
  end

  always_ff @(posedge clk)
    if (|i_we) r_mem[i_waddr] <= w_merged;

  always_ff @(posedge clk or negedge reset)
    if (!reset)    r_rdata <= '0;
    else if (i_re) r_rdata <= (|i_we && (i_waddr == i_raddr)) ? w_merged : r_mem[i_raddr];

  assign o_rdata = r_rdata;
endmodule

// File: rtl/dcache_write_through.sv
// Direct-mapped write-through, no-write-allocate dcache; stalls the pipeline around memory traffic.
module dcache_write_through
  import dcache_write_through_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CPU_ADDR_BITS-1:0] cpu_addr,
  input  logic                     cpu_re,
  input  logic [3:0]               cpu_we,
  input  logic [CPU_DATA_BITS-1:0] cpu_din,
  output logic [CPU_DATA_BITS-1:0] cpu_dout,
  output logic                     stall,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_rw,
  output logic [CPU_ADDR_BITS-1:0] mem_req_addr,
  output logic [CPU_DATA_BITS-1:0] mem_req_data,
  output logic [3:0]               mem_req_mask,
  input  logic                     mem_resp_valid,
  input  logic [CPU_DATA_BITS-1:0] mem_resp_data
);
  localparam int INDEX_BITS = $clog2(LINES);
  localparam int TAG_BITS   = CPU_ADDR_BITS - INDEX_BITS - 2;

  dcache_state_e r_state, w_state_nxt;

  logic [CPU_ADDR_BITS-1:2] r_addr;
  logic [3:0]               r_we;
  logic [CPU_DATA_BITS-1:0] r_din;
  logic                     r_pend_valid;
  logic [LINES-1:0]         r_valid;
  logic [TAG_BITS-1:0]      r_tag [LINES];
  logic [CPU_DATA_BITS-1:0] r_dout;

  logic [INDEX_BITS-1:0]    w_idx;
  logic [TAG_BITS-1:0]      w_tag;
  logic                     w_hit;
  logic                     w_is_wr;
  logic                     w_fill;
  logic [3:0]               w_arr_we;
  logic [CPU_DATA_BITS-1:0] w_arr_wdata;
  logic [CPU_DATA_BITS-1:0] w_rdata;
  logic                     w_unused;

  assign w_unused = ^cpu_addr[1:0];
  assign w_idx    = r_addr[INDEX_BITS+1:2];
  assign w_tag    = r_addr[CPU_ADDR_BITS-1:INDEX_BITS+2];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_is_wr  = |r_we;

  dcache_data_array #(.LINES(LINES), .DATA_W(CPU_DATA_BITS)) u_data (
    .clk     (clk),
    .reset   (reset),
    .i_re    (!stall),
    .i_raddr (cpu_addr[INDEX_BITS+1:2]),
    .i_we    (w_arr_we),
    .i_waddr (w_idx),
    .i_wdata (w_arr_wdata),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_state_nxt   = r_state;
    stall         = 1'b0;
    cpu_dout      = r_dout;
    mem_req_valid = 1'b0;
    mem_req_rw    = MEM_RW_READ;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    mem_req_mask  = '0;
    w_arr_we      = '0;
    w_arr_wdata   = r_din;
    w_fill        = 1'b0;
    case (r_state)
      DCACHE_READY: begin
        // Stores win over loads when both are flagged on the same request.
        if (r_pend_valid && w_is_wr) begin
          stall       = 1'b1;
          w_state_nxt = DCACHE_WR_REQ;
          if (w_hit) w_arr_we = r_we;
        end else if (r_pend_valid && w_hit) begin
          cpu_dout = w_rdata;
        end else if (r_pend_valid) begin
          stall       = 1'b1;
          w_state_nxt = DCACHE_RD_REQ;
        end
      end
      DCACHE_RD_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_addr  = {r_addr, 2'b00};
        if (mem_req_ready) w_state_nxt = DCACHE_RD_WAIT;
      end
      DCACHE_RD_WAIT: begin
        stall = 1'b1;
        if (mem_resp_valid) begin
          stall       = 1'b0;
          cpu_dout    = mem_resp_data;
          w_fill      = 1'b1;
          w_arr_we    = '1;
          w_arr_wdata = mem_resp_data;
          w_state_nxt = DCACHE_READY;
        end
      end
      DCACHE_WR_REQ: begin
        stall         = !mem_req_ready;
        mem_req_valid = 1'b1;
        mem_req_rw    = MEM_RW_WRITE;
        mem_req_addr  = {r_addr, 2'b00};
        mem_req_data  = r_din;
        mem_req_mask  = r_we;
        if (mem_req_ready) w_state_nxt = DCACHE_READY;
      end
      default: w_state_nxt = DCACHE_READY;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state      <= DCACHE_READY;
      r_addr       <= '0;
      r_we         <= '0;
      r_din        <= '0;
      r_pend_valid <= 1'b0;
      r_valid      <= '0;
      r_dout       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dout  <= cpu_dout;
      if (!stall) begin
        r_addr       <= cpu_addr[CPU_ADDR_BITS-1:2];
        r_we         <= cpu_we;
        r_din        <= cpu_din;
        r_pend_valid <= cpu_re | (|cpu_we);
      end
      if (w_fill) r_valid[w_idx] <= 1'b1;
    end

  // Tags need no reset: a cleared valid bit masks whatever they hold.
  always_ff @(posedge clk)
    if (w_fill) r_tag[w_idx] <= w_tag;
endmodule
